pc_trace_monitor: RTL and testbench
===================================

# pc_trace_monitor

Synthesizable program-flow monitor for the RV32 core's retire stream. It sits beside `core` in simulation and FPGA debug builds. Per retired instruction it classifies control flow as sequential or non-sequential, counts cycles and retires, and flags completion at a target PC or a hang via a watchdog. It also keeps the most recent retires in a circular trace buffer that a debug port can read back after the run freezes.

## Interface
Parameters:
- `XLEN`, 32: PC width.
- `DEPTH`, 16: trace entries; power of two, ≥2.
- `CNT_W`, 32: width of every counter.
- `TIMEOUT`, 1024: idle retire-free cycles before hang; 1 ≤ TIMEOUT < 2^CNT_W.
- `END_PC`, 32'h0000_0014: completion address.
- `INST_BYTES`, 4: sequential PC increment.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `en_i` in 1: monitor enable; low pauses RUN.
- `ret_valid_i` in 1: one instruction retired this cycle.
- `ret_pc_i` in XLEN: PC of retired instruction.
- `ret_inst_i` in 32: encoding of retired instruction.
- `cycle_cnt_o` out CNT_W: cycles spent in RUN with en_i high.
- `ret_cnt_o` out CNT_W: total retires recorded.
- `seq_cnt_o` out CNT_W: retires with PC = previous PC + INST_BYTES.
- `jump_cnt_o` out CNT_W: retires with any other PC.
- `state_o` out 2: IDLE=0, RUN=1, DONE=2, HUNG=3.
- `done_o` out 1: sticky, END_PC reached.
- `timeout_o` out 1: sticky, watchdog expired.
- `rd_idx_i` in $clog2(DEPTH): trace index; 0 = newest.
- `rd_valid_o` out 1: rd_idx_i < number of stored entries.
- `rd_pc_o` out XLEN: PC of selected entry.
- `rd_inst_o` out 32: encoding of selected entry.

## Operation
- Reset: state IDLE; all counters, last_pc, wr_ptr, fill count and stall counter 0; done_o, timeout_o 0; trace storage contents don't-care, masked by rd_valid_o.
- IDLE → RUN: on a cycle with en_i=1 and ret_valid_i=1. That retire is recorded (ret_cnt=1, trace entry written) and not classified.
- RUN with en_i=0: everything holds and retires are ignored.
- RUN with en_i=1, per cycle:
  - cycle_cnt increments.
  - If ret_valid_i=0, the stall counter increments.
  - If ret_valid_i=1:
    - stall counter clears; ret_cnt increments.
    - The retire is classified seq or jump against last_pc + INST_BYTES. The add is modulo 2^XLEN, so a wrap from the top address counts as sequential.
    - last_pc ← ret_pc_i.
    - The trace entry is written at wr_ptr, then wr_ptr increments mod DEPTH; the fill count saturates at DEPTH.
- Completion: a recorded retire with ret_pc_i ≥ END_PC (unsigned) moves to DONE and sets done_o. That retire is recorded and classified.
- Hang: when the stall counter would reach TIMEOUT, move to HUNG and set timeout_o.
- Simultaneous events: a retire in the same cycle resets the watchdog, so DONE always beats HUNG.
- DONE and HUNG are terminal. Counters and trace freeze; only rst leaves them.
- Counters saturate at all-ones and never wrap.
- Trace read is combinational, from the entry at (wr_ptr − 1 − rd_idx_i) mod DEPTH. When rd_valid_o=0, rd_pc_o and rd_inst_o are 0.

## Timing
- Every output except the read port is registered.
- A retire sampled at edge N is visible on counters, state_o and done_o after edge N, i.e. one cycle of latency.
- The read port reflects trace state in the same cycle as the write edge.
- No handshake back-pressure: the monitor accepts a retire on every cycle.
- Reset asserted mid-run clears state immediately, without waiting for a clock edge.

## Structure
- Package `pc_mon_pkg`: state enum (IDLE/RUN/DONE/HUNG) and the state_o encoding.
- Sub-module `pc_trace_ram`: DEPTH×(XLEN+32) storage with one write port and an asynchronous read port, holding pointer and fill logic. It is instantiated once.
- Top level holds the FSM, classifier, counters and watchdog.

## Test plan
1. Straight-line retires with PC 0,4,8,…,0x14 on consecutive cycles:
   - done_o=1 after the 0x14 retire.
   - ret_cnt=6, seq_cnt=5, jump_cnt=0, state_o=2.
2. Retires with PC 0,4,0x40,0x44, END_PC=0x1000:
   - seq_cnt=2, jump_cnt=1.
   - Reading idx0..3 returns 0x44, 0x40, 4, 0; idx4 reads rd_valid_o=0.
3. One retire at PC 0, then no retires, TIMEOUT=8:
   - timeout_o rises exactly 8 cycles after the retire edge; state_o=3.
   - Later retires do not change the counters.
4. DEPTH=4, ten sequential retires from PC 0:
   - fill count 4; idx0=0x24, idx3=0x18.
   - Trace is unchanged after a further retire once DONE or HUNG is reached.
5. en_i dropped for 5 cycles mid-run while retires and idle cycles occur:
   - cycle_cnt, ret_cnt and stall counter unchanged across the window.
   - No timeout even when window plus stalls exceeds TIMEOUT.
6. rst pulsed between clock edges in RUN:
   - All outputs reach reset values without a clock edge.
   - The next valid retire re-enters RUN with ret_cnt=1.

Source files
------------

// File: rtl/pc_mon_pkg.sv
// Shared definitions for the retire-stream program-flow monitor.
// The state encoding doubles as the externally visible state_o value.
package pc_mon_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        HUNG = 2'd3
    } mon_state_t;

endpackage

// File: rtl/pc_trace_ram.sv
// Circular trace of recent retires (PC + encoding) with a combinational read port.
// Index 0 on the read port selects the newest entry.
module pc_trace_ram #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [XLEN-1:0]          wr_pc,
    input  logic [31:0]              wr_inst,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_inst
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   fill;
    logic [PTR_W-1:0] rd_addr;

    // Storage has no reset; stale entries are hidden by the fill count.
    always_ff @(posedge clk) begin
        if (we) begin
            pc_mem[wr_ptr]   <= wr_pc;
            inst_mem[wr_ptr] <= wr_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (we) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (fill != (PTR_W+1)'(DEPTH))
                fill <= fill + (PTR_W+1)'(1);
        end
    end

    // Power-of-two depth makes the pointer arithmetic wrap naturally.
    always_comb begin
        rd_addr  = wr_ptr - PTR_W'(1) - rd_idx;
        rd_valid = ({1'b0, rd_idx} < fill);
        rd_pc    = '0;
        rd_inst  = '0;
        if (rd_valid) begin
            rd_pc   = pc_mem[rd_addr];
            rd_inst = inst_mem[rd_addr];
        end
    end

endmodule

// File: rtl/pc_trace_monitor.sv
// Retire-stream monitor: classifies control flow, counts cycles/retires,
// detects completion at END_PC or a retire-free hang, and records a trace.
module pc_trace_monitor
    import pc_mon_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     DEPTH      = 16,
    parameter int unsigned     CNT_W      = 32,
    parameter int unsigned     TIMEOUT    = 1024,
    parameter logic [XLEN-1:0] END_PC     = 32'h0000_0014,
    parameter int unsigned     INST_BYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     ret_valid_i,
    input  logic [XLEN-1:0]          ret_pc_i,
    input  logic [31:0]              ret_inst_i,
    output logic [CNT_W-1:0]         cycle_cnt_o,
    output logic [CNT_W-1:0]         ret_cnt_o,
    output logic [CNT_W-1:0]         seq_cnt_o,
    output logic [CNT_W-1:0]         jump_cnt_o,
    output logic [STATE_W-1:0]       state_o,
    output logic                     done_o,
    output logic                     timeout_o,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic                     rd_valid_o,
    output logic [XLEN-1:0]          rd_pc_o,
    output logic [31:0]              rd_inst_o
);

    mon_state_t       state_q,   state_d;
    logic [CNT_W-1:0] cycle_q,   cycle_d;
    logic [CNT_W-1:0] ret_q,     ret_d;
    logic [CNT_W-1:0] seq_q,     seq_d;
    logic [CNT_W-1:0] jump_q,    jump_d;
    logic [CNT_W-1:0] stall_q,   stall_d;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic             done_q,    done_d;
    logic             timeout_q, timeout_d;
    logic             rec;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cycle_q   <= '0;
            ret_q     <= '0;
            seq_q     <= '0;
            jump_q    <= '0;
            stall_q   <= '0;
            last_pc_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            ret_q     <= ret_d;
            seq_q     <= seq_d;
            jump_q    <= jump_d;
            stall_q   <= stall_d;
            last_pc_q <= last_pc_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        ret_d     = ret_q;
        seq_d     = seq_q;
        jump_d    = jump_q;
        stall_d   = stall_q;
        last_pc_d = last_pc_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        rec       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The first retire only seeds last_pc; it is not classified.
                if (en_i && ret_valid_i) begin
                    rec       = 1'b1;
                    ret_d     = sat_inc(ret_q);
                    last_pc_d = ret_pc_i;
                    state_d   = RUN;
                    if (ret_pc_i >= END_PC) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (en_i) begin
                    cycle_d = sat_inc(cycle_q);
                    if (ret_valid_i) begin
                        rec       = 1'b1;
                        stall_d   = '0;
                        ret_d     = sat_inc(ret_q);
                        last_pc_d = ret_pc_i;
                        if (ret_pc_i == last_pc_q + XLEN'(INST_BYTES))
                            seq_d = sat_inc(seq_q);
                        else
                            jump_d = sat_inc(jump_q);
                        if (ret_pc_i >= END_PC) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        // A retire in this cycle takes the other branch, so DONE wins over HUNG.
                        stall_d = stall_q + CNT_W'(1);
                        if (stall_d == CNT_W'(TIMEOUT)) begin
                            state_d   = HUNG;
                            timeout_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign cycle_cnt_o = cycle_q;
    assign ret_cnt_o   = ret_q;
    assign seq_cnt_o   = seq_q;
    assign jump_cnt_o  = jump_q;
    assign state_o     = state_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;

    pc_trace_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_trace (
        .clk      (clk),
        .rst      (rst),
        .we       (rec),
        .wr_pc    (ret_pc_i),
        .wr_inst  (ret_inst_i),
        .rd_idx   (rd_idx_i),
        .rd_valid (rd_valid_o),
        .rd_pc    (rd_pc_o),
        .rd_inst  (rd_inst_o)
    );

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Scoreboard bench: stimulus queues expected values tagged with a cycle,
// a monitor compares them against three differently parameterised monitors.
module tb_pc_trace_monitor;

    localparam int S_CYC = 0, S_RET = 1, S_SEQ = 2, S_JMP = 3, S_ST = 4,
                   S_DONE = 5, S_TO = 6, S_RDV = 7, S_RDPC = 8, S_RDINST = 9;

    typedef struct {
        int          tag;
        int          inst;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] rpc = '0;
    logic [31:0] rinst = '0;
    logic [3:0]  rd_idx = '0;

    logic [31:0] cyc_w [3];
    logic [31:0] ret_w [3];
    logic [31:0] seq_w [3];
    logic [31:0] jmp_w [3];
    logic [1:0]  st_w  [3];
    logic        dn_w  [3];
    logic        to_w  [3];
    logic        rdv_w [3];
    logic [31:0] rdpc_w[3];
    logic [31:0] rdin_w[3];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    event chk_now;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u1: TIMEOUT 8, END_PC 0x14
    pc_trace_monitor #(.XLEN(32), .DEPTH(16), .CNT_W(32), .TIMEOUT(8),
                       .END_PC(32'h14), .INST_BYTES(4)) u1 (
        .clk(clk), .rst(rst), .en_i(en), .ret_valid_i(rv), .ret_pc_i(rpc),
        .ret_inst_i(rinst), .cycle_cnt_o(cyc_w[0]), .ret_cnt_o(ret_w[0]),
        .seq_cnt_o(seq_w[0]), .jump_cnt_o(jmp_w[0]), .state_o(st_w[0]),
        .done_o(dn_w[0]), .timeout_o(to_w[0]), .rd_idx_i(rd_idx),
        .rd_valid_o(rdv_w[0]), .rd_pc_o(rdpc_w[0]), .rd_inst_o(rdin_w[0]));

    // u2: END_PC 0x1000
    pc_trace_monitor #(.XLEN(32), .DEPTH(16), .CNT_W(32), .TIMEOUT(1024),
                       .END_PC(32'h1000), .INST_BYTES(4)) u2 (
        .clk(clk), .rst(rst), .en_i(en), .ret_valid_i(rv), .ret_pc_i(rpc),
        .ret_inst_i(rinst), .cycle_cnt_o(cyc_w[1]), .ret_cnt_o(ret_w[1]),
        .seq_cnt_o(seq_w[1]), .jump_cnt_o(jmp_w[1]), .state_o(st_w[1]),
        .done_o(dn_w[1]), .timeout_o(to_w[1]), .rd_idx_i(rd_idx),
        .rd_valid_o(rdv_w[1]), .rd_pc_o(rdpc_w[1]), .rd_inst_o(rdin_w[1]));

    // u3: DEPTH 4, END_PC 0x24
    pc_trace_monitor #(.XLEN(32), .DEPTH(4), .CNT_W(32), .TIMEOUT(1024),
                       .END_PC(32'h24), .INST_BYTES(4)) u3 (
        .clk(clk), .rst(rst), .en_i(en), .ret_valid_i(rv), .ret_pc_i(rpc),
        .ret_inst_i(rinst), .cycle_cnt_o(cyc_w[2]), .ret_cnt_o(ret_w[2]),
        .seq_cnt_o(seq_w[2]), .jump_cnt_o(jmp_w[2]), .state_o(st_w[2]),
        .done_o(dn_w[2]), .timeout_o(to_w[2]), .rd_idx_i(rd_idx[1:0]),
        .rd_valid_o(rdv_w[2]), .rd_pc_o(rdpc_w[2]), .rd_inst_o(rdin_w[2]));

    function automatic logic [31:0] act(input int i, input int s);
        case (s)
            S_CYC:    return cyc_w[i];
            S_RET:    return ret_w[i];
            S_SEQ:    return seq_w[i];
            S_JMP:    return jmp_w[i];
            S_ST:     return {30'd0, st_w[i]};
            S_DONE:   return {31'd0, dn_w[i]};
            S_TO:     return {31'd0, to_w[i]};
            S_RDV:    return {31'd0, rdv_w[i]};
            S_RDPC:   return rdpc_w[i];
            default:  return rdin_w[i];
        endcase
    endfunction

    // Monitor: compares every queued expectation whose cycle has arrived.
    initial begin
        forever begin
            @(negedge clk or chk_now);
            while (q.size() > 0 && q[0].tag <= cyc) begin
                exp_t e;
                logic [31:0] a;
                e = q.pop_front();
                a = act(e.inst, e.sel);
                n_cmp++;
                if (a !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
                end
            end
        end
    end

    task automatic expect_v(input int i, input int s, input logic [31:0] v, input string nm);
        exp_t e;
        e.tag = cyc; e.inst = i; e.sel = s; e.exp = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc);
        rv = 1'b1;
        rpc = pc;
        rinst = pc ^ 32'h1357_0000;
        tick();
        rv = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tick();
        rst = 1'b0;
        en = 1'b1;
        pulse_reset();
        expect_v(0, S_ST, 0, "reset_state");
        expect_v(0, S_RET, 0, "reset_ret");
        expect_v(0, S_CYC, 0, "reset_cyc");
        expect_v(0, S_RDV, 0, "reset_rdv");
        expect_v(0, S_RDPC, 0, "reset_rdpc");
        settle();

        // 1: straight-line run to END_PC
        for (int k = 0; k < 5; k++) retire(32'(k * 4));
        expect_v(0, S_DONE, 0, "t1_done_before_end");
        expect_v(0, S_ST, 1, "t1_state_run");
        retire(32'h14);
        expect_v(0, S_DONE, 1, "t1_done");
        expect_v(0, S_ST, 2, "t1_state_done");
        expect_v(0, S_RET, 6, "t1_ret");
        expect_v(0, S_SEQ, 5, "t1_seq");
        expect_v(0, S_JMP, 0, "t1_jump");
        expect_v(0, S_CYC, 5, "t1_cycles");
        expect_v(0, S_RDPC, 32'h14, "t1_rd0_pc");
        expect_v(0, S_RDINST, 32'h1357_0014, "t1_rd0_inst");
        settle();

        // 2: jump classification and trace read-back
        pulse_reset();
        retire(32'h0); retire(32'h4); retire(32'h40); retire(32'h44);
        expect_v(1, S_SEQ, 2, "t2_seq");
        expect_v(1, S_JMP, 1, "t2_jump");
        expect_v(1, S_ST, 1, "t2_state");
        settle();
        begin
            logic [31:0] pcs [4];
            pcs = '{32'h44, 32'h40, 32'h4, 32'h0};
            for (int k = 0; k < 4; k++) begin
                rd_idx = 4'(k);
                expect_v(1, S_RDV, 1, "t2_rdv");
                expect_v(1, S_RDPC, pcs[k], "t2_rdpc");
                expect_v(1, S_RDINST, pcs[k] ^ 32'h1357_0000, "t2_rdinst");
                settle();
            end
        end
        rd_idx = 4'd4;
        expect_v(1, S_RDV, 0, "t2_idx4_rdv");
        expect_v(1, S_RDPC, 0, "t2_idx4_rdpc");
        settle();
        rd_idx = '0;

        // 3: watchdog fires exactly TIMEOUT cycles after the last retire
        pulse_reset();
        retire(32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) expect_v(0, S_TO, 0, "t3_no_timeout_yet");
        end
        expect_v(0, S_TO, 1, "t3_timeout");
        expect_v(0, S_ST, 3, "t3_state_hung");
        expect_v(0, S_CYC, 8, "t3_cycles");
        retire(32'h4);
        expect_v(0, S_RET, 1, "t3_ret_frozen");
        expect_v(0, S_SEQ, 0, "t3_seq_frozen");
        expect_v(0, S_CYC, 8, "t3_cyc_frozen");
        settle();

        // 4: small ring wraps; freeze after DONE
        pulse_reset();
        for (int k = 0; k < 10; k++) retire(32'(k * 4));
        expect_v(2, S_ST, 2, "t4_state_done");
        expect_v(2, S_RET, 10, "t4_ret");
        expect_v(2, S_SEQ, 9, "t4_seq");
        settle();
        rd_idx = 4'd3;
        expect_v(2, S_RDV, 1, "t4_idx3_rdv");
        expect_v(2, S_RDPC, 32'h18, "t4_idx3_pc");
        settle();
        rd_idx = 4'd0;
        retire(32'h100);
        expect_v(2, S_RDPC, 32'h24, "t4_idx0_pc_frozen");
        expect_v(2, S_RET, 10, "t4_ret_frozen");
        settle();

        // 5: en_i low window holds counters and the stall count
        pulse_reset();
        retire(32'h0);
        tick(); tick(); tick();
        en = 1'b0;
        retire(32'h4); tick(); retire(32'h14); tick(); tick();
        en = 1'b1;
        expect_v(0, S_RET, 1, "t5_ret_held");
        expect_v(0, S_CYC, 3, "t5_cyc_held");
        expect_v(0, S_DONE, 0, "t5_done_ignored");
        settle();
        tick(); tick(); tick(); tick();
        expect_v(0, S_TO, 0, "t5_no_timeout");
        expect_v(0, S_ST, 1, "t5_state_run");
        tick();
        expect_v(0, S_TO, 1, "t5_timeout_after_stalls");
        expect_v(0, S_CYC, 8, "t5_cycles");
        settle();

        // 6: asynchronous reset mid-run
        pulse_reset();
        retire(32'h0); retire(32'h4);
        #1 rst = 1'b1;
        #1;
        expect_v(0, S_ST, 0, "t6_state");
        expect_v(0, S_RET, 0, "t6_ret");
        expect_v(0, S_SEQ, 0, "t6_seq");
        expect_v(0, S_CYC, 0, "t6_cyc");
        expect_v(0, S_RDV, 0, "t6_rdv");
        ->chk_now;
        #1 rst = 1'b0;
        retire(32'h8);
        expect_v(0, S_ST, 1, "t6_rerun_state");
        expect_v(0, S_RET, 1, "t6_rerun_ret");
        expect_v(0, S_JMP, 0, "t6_rerun_jump");
        expect_v(0, S_RDPC, 32'h8, "t6_rerun_rd0");
        settle();

        for (int k = 0; k < 10 && q.size() > 0; k++) settle();
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
